// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: groups the next-PC request signals and the PC outputs that
// run between the next-PC logic (master) and pc_seq_unit (slave).
interface pc_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic             ret;
    logic             halt_req;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             pc_valid;
    logic             halted;
    logic             misalign;
    logic             ras_empty;

    // Next-PC logic: drives requests, observes the PC.
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               call, ret, halt_req, resume,
        input  pc, pc_plus, pc_valid, halted, misalign, ras_empty
    );

    // PC sequencer: consumes requests, owns the PC.
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               call, ret, halt_req, resume,
        output pc, pc_plus, pc_valid, halted, misalign, ras_empty
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter sequencer for the single-cycle MIPS datapath.
// Holds the PC, resolves halt > jump > branch > stall > increment, and runs a
// BOOT/RUN/HALT control FSM. Define PC_RAS_EN to add a circular return-address
// stack that serves ret redirects; without it ras_empty is tied high.
module pc_seq_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_seq_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             pc_valid;
    logic             halted;
    logic             misalign;
    logic             accept;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             ras_hit;
    logic [WIDTH-1:0] ras_top_val;

    assign pc_plus = pc + WIDTH'(INC);

    // A redirect or stack operation is only honoured in RUN without a halt request.
    assign accept   = (state == S_RUN) && !bus.halt_req;
    assign redirect = bus.jump || bus.branch_taken;

    // Select the raw redirect target: jump beats branch, a ret with a live stack
    // entry takes the stacked address instead of jump_target.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        target = bus.branch_target;
        if (bus.jump) begin
            target = (bus.ret && ras_hit) ? ras_top_val : bus.jump_target;
        end
    end

    // Control FSM and PC register; pc_valid, halted and misalign are registered.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                S_BOOT: begin
                    state    <= S_RUN;
                    pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (bus.halt_req) begin
                        state    <= S_HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (redirect) begin
                        pc       <= {target[WIDTH-1:2], 2'b00};
                        misalign <= |target[1:0];
                    end else if (!bus.stall) begin
                        pc <= pc_plus;
                    end
                end
                S_HALT: begin
                    if (bus.resume && !bus.halt_req) begin
                        state    <= S_RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [PW:0]      ras_count;
    logic             ras_push;
    logic             ras_pop;

    // ret wins over call when both are set, so a push needs ret low.
    assign ras_push    = accept && bus.jump && bus.call && !bus.ret;
    assign ras_pop     = accept && bus.jump && bus.ret && ras_hit;
    assign ras_hit     = (ras_count != '0);
    assign ras_top_val = ras_mem[ras_top];
    assign bus.ras_empty = !ras_hit;

    // Stack pointer and occupancy; a push when full overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_top   <= '0;
            ras_count <= '0;
        end else if (ras_push) begin
            ras_top <= ras_top + 1'b1;
            if (ras_count != RAS_FULL) begin
                ras_count <= ras_count + 1'b1;
            end
        end else if (ras_pop) begin
            ras_top   <= ras_top - 1'b1;
            ras_count <= ras_count - 1'b1;
        end
    end

    // Return-address storage, written with the address after the call.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; clearing ras_count makes stale entries unreachable.
        if (ras_push) begin
            ras_mem[ras_top + 1'b1] <= pc_plus;
        end
    end
`else
    logic ras_cfg_unused;

    assign ras_cfg_unused = (RAS_DEPTH >= 2);
    assign ras_hit        = 1'b0;
    assign ras_top_val    = '0;
    assign bus.ras_empty  = 1'b1;
`endif

    assign bus.pc       = pc;
    assign bus.pc_plus  = pc_plus;
    assign bus.pc_valid = pc_valid;
    assign bus.halted   = halted;
    assign bus.misalign = misalign;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed checks of pc_seq_unit (WIDTH=32, RESET_VEC=0,
// INC=4, RAS_DEPTH=4). The return-stack steps run when PC_RAS_EN is defined.
module tb_pc_seq_unit;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    pc_seq_unit_if #(.WIDTH(32)) bus ();

    pc_seq_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h0000_0000),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.jump = 0; bus.jump_target = '0; bus.call = 0; bus.ret = 0;
        bus.halt_req = 0; bus.resume = 0;
    endtask

    task automatic do_jump(input logic [31:0] t, input logic c, input logic r);
        idle();
        bus.jump = 1; bus.jump_target = t; bus.call = c; bus.ret = r;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        // Reset state
        check("rst_pc", bus.pc, 32'h0);
        check("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
        check("rst_halted", {31'b0, bus.halted}, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        check("rst_ras_empty", {31'b0, bus.ras_empty}, 32'h1);
        check("rst_pc_plus", bus.pc_plus, 32'h4);

        // BOOT lasts one cycle, then sequential fetch
        @(negedge clk); rst = 1'b1; #1;
        check("boot_valid", {31'b0, bus.pc_valid}, 32'h0);
        tick();
        check("run0_pc", bus.pc, 32'h0);
        check("run0_valid", {31'b0, bus.pc_valid}, 32'h1);
        tick(); check("seq_4", bus.pc, 32'h4);
        tick(); check("seq_8", bus.pc, 32'h8);
        tick(); check("seq_c", bus.pc, 32'hC);

        // Priority: jump beats branch and stall
        do_jump(32'h100, 0, 0);
        check("jump_100", bus.pc, 32'h100);
        bus.jump = 1; bus.jump_target = 32'h400;
        bus.branch_taken = 1; bus.branch_target = 32'h200; bus.stall = 1;
        tick(); idle();
        check("prio_jump", bus.pc, 32'h400);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", bus.pc, 32'h400);
        end
        // Branch overrides stall
        bus.branch_taken = 1; bus.branch_target = 32'h20;
        tick(); idle();
        check("branch_stall", bus.pc, 32'h20);

        // Halt
        bus.halt_req = 1; tick(); idle();
        check("halt_flag", {31'b0, bus.halted}, 32'h1);
        check("halt_pc", bus.pc, 32'h20);
        check("halt_valid", {31'b0, bus.pc_valid}, 32'h0);
        do_jump(32'h500, 0, 0);
        check("halt_jump_ign", bus.pc, 32'h20);
        bus.halt_req = 1; bus.resume = 1; tick(); idle();
        check("halt_and_resume", {31'b0, bus.halted}, 32'h1);
        bus.resume = 1; tick(); idle();
        check("resume_halted", {31'b0, bus.halted}, 32'h0);
        check("resume_valid", {31'b0, bus.pc_valid}, 32'h1);
        check("resume_pc", bus.pc, 32'h20);
        tick(); check("resume_next", bus.pc, 32'h24);

        // Wrap
        do_jump(32'hFFFF_FFFC, 0, 0);
        check("wrap_pc_plus", bus.pc_plus, 32'h0);
        tick(); check("wrap_pc", bus.pc, 32'h0);

        // Alignment
        do_jump(32'h103, 0, 0);
        check("align_jump", bus.pc, 32'h100);
        check("misalign_pulse", {31'b0, bus.misalign}, 32'h1);
        tick();
        check("misalign_clear", {31'b0, bus.misalign}, 32'h0);
        check("after_align", bus.pc, 32'h104);
        bus.branch_taken = 1; bus.branch_target = 32'h202; tick(); idle();
        check("align_branch", bus.pc, 32'h200);
        check("misalign_branch", {31'b0, bus.misalign}, 32'h1);

        // call without jump ignored; call+ret with empty stack is a plain jump
        bus.call = 1; bus.ret = 1; tick(); idle();
        check("callret_nojump", bus.pc, 32'h204);
        check("callret_nojump_ras", {31'b0, bus.ras_empty}, 32'h1);
        do_jump(32'h300, 1, 1);
        check("ret_plain", bus.pc, 32'h300);
        check("ret_plain_ras", {31'b0, bus.ras_empty}, 32'h1);

`ifdef PC_RAS_EN
        // Return-address stack
        do_jump(32'h10, 0, 0);
        do_jump(32'h80, 1, 0);
        check("ras_call_pc", bus.pc, 32'h80);
        check("ras_call_nonempty", {31'b0, bus.ras_empty}, 32'h0);
        do_jump(32'hDEAD_0000, 0, 1);
        check("ras_ret_pc", bus.pc, 32'h14);
        check("ras_ret_empty", {31'b0, bus.ras_empty}, 32'h1);
        do_jump(32'h1000, 1, 0);
        do_jump(32'h2000, 1, 0);
        do_jump(32'h3000, 1, 0);
        do_jump(32'h4000, 1, 0);
        do_jump(32'h5000, 1, 0);
        do_jump(32'h7000, 0, 1); check("ras_pop1", bus.pc, 32'h4004);
        do_jump(32'h7000, 0, 1); check("ras_pop2", bus.pc, 32'h3004);
        do_jump(32'h7000, 0, 1); check("ras_pop3", bus.pc, 32'h2004);
        do_jump(32'h7000, 0, 1); check("ras_pop4", bus.pc, 32'h1004);
        check("ras_drained", {31'b0, bus.ras_empty}, 32'h1);
        do_jump(32'h7000, 0, 1); check("ras_pop5_target", bus.pc, 32'h7000);
`endif

        // Async reset mid-run at pc=0x40 with two stacked returns
        do_jump(32'h600, 1, 0);
        do_jump(32'h40, 1, 0);
        check("pre_reset_pc", bus.pc, 32'h40);
        check("pre_reset_ras", {31'b0, bus.ras_empty}, RAS_ON ? 32'h0 : 32'h1);
        #2 rst = 1'b0; #1;
        check("async_pc", bus.pc, 32'h0);
        check("async_ras_empty", {31'b0, bus.ras_empty}, 32'h1);
        check("async_valid", {31'b0, bus.pc_valid}, 32'h0);
        @(negedge clk); rst = 1'b1; #1;
        check("reboot_valid", {31'b0, bus.pc_valid}, 32'h0);
        tick();
        check("reboot_run_valid", {31'b0, bus.pc_valid}, 32'h1);
        check("reboot_run_pc", bus.pc, 32'h0);
        tick(); check("reboot_seq", bus.pc, 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised next-generation program counter for the single-cycle MIPS datapath. Sits between the next-PC logic and the instruction memory address port.
- Holds the PC register and adds a configurable reset vector and sequential increment.
- Resolves jump, branch and stall by fixed priority, and adds a RUN/HALT/BOOT control FSM.
- Optionally adds a return-address stack for call/return acceleration.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; truncated to WIDTH.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2); used only with PC_RAS_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (PC and FSM cleared while low)
- stall  in  1  hold PC this cycle
- branch_taken  in  1  take branch_target this cycle
- branch_target  in  WIDTH  branch destination
- jump  in  1  take jump_target this cycle
- jump_target  in  WIDTH  jump/return destination
- call  in  1  qualifies jump as a call (push return address)
- ret  in  1  qualifies jump as a return
- halt_req  in  1  request halt
- resume  in  1  leave HALT
- pc  out  WIDTH  current PC to instruction memory
- pc_plus  out  WIDTH  pc + INC, combinational
- pc_valid  out  1  pc is a fetch address to be executed
- halted  out  1  FSM in HALT
- misalign  out  1  one-cycle pulse: accepted target had nonzero bits [1:0]
- ras_empty  out  1  return stack empty (tied 1 without PC_RAS_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. All state updates on posedge clk.
- Reset values: pc=RESET_VEC, FSM=BOOT, pc_valid=0, halted=0, misalign=0, RAS count=0, ras_empty=1.
- Reset asserted mid-operation: all of the above reapply immediately, regardless of clock. Pending halt and RAS contents are discarded.
- Arithmetic: pc_plus = (pc + INC) mod 2^WIDTH; wrap from all-ones region to low addresses is silent. No other arithmetic.
- Target alignment: accepted targets have bits [1:0] forced to 0. If the original bits were nonzero, misalign=1 for the following cycle.
- FSM BOOT: lasts exactly one cycle after reset release. pc holds RESET_VEC, pc_valid=0. Next state is RUN unconditionally; inputs are ignored.
- FSM RUN: pc_valid=1. Next-PC priority, highest first:
  1. halt_req: go to HALT; pc unchanged.
  2. jump: pc <= jump_target (or RAS top for ret, see Optional Feature).
  3. branch_taken: pc <= branch_target.
  4. stall: pc unchanged.
  5. Otherwise: pc <= pc_plus.
- Redirects override stall: jump or branch during stall still loads the target.
- jump and branch_taken together: jump wins; the branch is dropped.
- call/ret without jump: ignored. call and ret together: treated as ret.
- FSM HALT: halted=1, pc_valid=0, pc frozen; all redirect inputs ignored.
  - resume=1: go to RUN next cycle with the same pc.
  - halt_req and resume together in HALT: stay in HALT.
- Latency: every accepted update appears on pc one cycle after the sampling edge. No combinational path from inputs to pc.
- Without PC_RAS_EN, ret behaves as a plain jump.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS_DEPTH-entry circular stack of WIDTH-bit return addresses.
  - Accepted call (RUN, jump=1, call=1, ret=0): push pc_plus.
  - Accepted ret with stack non-empty: pc <= top entry, pop; jump_target is ignored.
  - ret when empty: use jump_target; count stays 0.
  - Push when full: overwrites the oldest entry; count saturates at RAS_DEPTH.
  - ras_empty = (count==0). Stack is untouched during HALT or when the redirect is not accepted.
- Undefined: no stack storage; ras_empty tied 1; ret equals a plain jump to jump_target.

Test Plan:
- Reset: rst low, then release. pc=0 with pc_valid=0 for one cycle (BOOT). Then 0x4, 0x8, 0xC with pc_valid=1.
- Priority: from pc=0x100, assert jump=1 (0x400), branch_taken=1 (0x200) and stall=1 together. Next pc=0x400. Then stall alone holds 0x400 for 3 cycles.
- Halt: halt_req at pc=0x20 -> halted=1, pc stays 0x20, pc_valid=0; jump during HALT ignored. resume -> RUN, next pc 0x24.
- Wrap and alignment: WIDTH=32, pc=0xFFFF_FFFC -> next pc 0x0. jump_target=0x103 -> pc=0x100 and one-cycle misalign pulse.
- RAS (PC_RAS_EN, RAS_DEPTH=4), at pc=0x10:
  - call to 0x80 pushes 0x14; ret with jump_target=0xDEAD_0000 -> pc=0x14, ras_empty=1.
  - 5 calls then 5 rets: the first 4 rets return the newest 4 addresses; the fifth uses jump_target.
- Async reset mid-run: drop rst between edges at pc=0x40 with RAS holding 2 entries. pc reads RESET_VEC immediately, ras_empty=1, and BOOT repeats on release.
